// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB3 completer fronting a small flop-based register bank, with a fixed,
//   parameterized number of wait states inserted before each completion.
//
// Ports
//   PCLK     clock, all state updates on the rising edge
//   PRESETn  asynchronous active-low reset
//   PSEL     completer select
//   PENABLE  access-phase indicator
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address (ADDR_WIDTH)
//   PWDATA   write data (DATA_WIDTH)
//   PRDATA   read data, registered; valid while PREADY=1 on a read, and held
//            until the next read completes
//   PREADY   registered transfer completion
//   PSLVERR  registered error response, valid while PREADY=1
//
// Optional feature
//   APB_SLV_ERR_EN  when defined, transfers to addresses >= MEM_DEPTH complete
//                   with PSLVERR=1. When undefined PSLVERR is constant 0.
//                   Out-of-range writes are always dropped and out-of-range
//                   reads always return 0.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,   // must be <= 2**ADDR_WIDTH
  parameter int WAIT_STATES = 2     // 0..15
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Depth widened by one bit so MEM_DEPTH == 2**ADDR_WIDTH still compares.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]          CNT_INIT  = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  setup, access;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_wr;
  logic                  ld_in_range;
  logic                  wr_in_range;
  logic                  ld_err;
  logic                  load_out;
  logic [DATA_WIDTH-1:0] ld_rdata;

  assign setup  = PSEL && !PENABLE;
  assign access = PSEL && PENABLE;

  // The response registers are loaded either on the setup edge itself
  // (zero wait states, transfer attributes still on the bus) or on the edge
  // where the counter reaches zero (attributes already captured).
  always_comb begin
    ld_addr = addr_q;
    ld_wr   = wr_q;
    if (state == IDLE) begin
      ld_addr = PADDR;
      ld_wr   = PWRITE;
    end
  end

  // Full-width unsigned compare: no aliasing of high addresses onto the bank.
  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, addr_q}  < DEPTH_LIM);
  assign ld_rdata    = ld_in_range ? mem[ld_addr[IDX_W-1:0]] : '0;

`ifdef APB_SLV_ERR_EN
  assign ld_err = !ld_in_range;
`else
  assign ld_err = 1'b0;
`endif

  assign load_out = ((state == IDLE)   && setup  && (WAIT_STATES == 0)) ||
                    ((state == ACCESS) && access && (cnt == 4'd1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // PSEL&&PENABLE without a preceding setup is ignored here.
          if (setup) begin
            addr_q <= PADDR;
            wr_q   <= PWRITE;
            wd_q   <= PWDATA;
            cnt    <= CNT_INIT;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            // Requester abandoned the transfer: drop it, nothing is written.
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (PENABLE) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              // Completion edge: PREADY has been high for this cycle.
              if (wr_q && wr_in_range) mem[addr_q[IDX_W-1:0]] <= wd_q;
              PREADY  <= 1'b0;
              PSLVERR <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load_out) begin
        PREADY  <= 1'b1;
        PSLVERR <= ld_err;
        if (!ld_wr) PRDATA <= ld_rdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem (default parameters, WAIT_STATES=2).
// A driver issues APB transfers and queues the expected response; a monitor
// pops and checks each completion (PREADY=1 in the access phase).
module tb_apb_slave_mem;

  localparam int WS = 2;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;

  apb_slave_mem #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(WS)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

`ifdef APB_SLV_ERR_EN
  localparam logic OOR_ERR = 1'b1;
`else
  localparam logic OOR_ERR = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
    end
  endtask

  // Monitor: latency counts negedges from the first access cycle up to and
  // including the one where PREADY is observed high.
  int lat = 0;
  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESETn) lat = 0;
    else if (PSEL && !PENABLE) lat = 0;
    else if (PSEL && PENABLE) begin
      lat++;
      if (PREADY) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_completion: addr 0x%02h with empty queue", PADDR);
        end else begin
          e = q.pop_front();
          chk($sformatf("pslverr@%02h", PADDR), {7'd0, PSLVERR}, {7'd0, e.err});
          chk($sformatf("latency@%02h", PADDR), 8'(lat), 8'(e.lat));
          if (!e.wr) chk($sformatf("prdata@%02h", PADDR), PRDATA, e.data);
        end
      end
    end
  end

  // Full transfer; leaves bus idle at posedge+1 so a following call is
  // back-to-back with no idle cycle.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e);
    exp_t e;
    bit   ok;
    e.wr = wr; e.data = exp_d; e.err = exp_e; e.lat = WS + 1;
    q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (PREADY) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL timeout: no PREADY for addr 0x%02h", a);
    end
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_pready",  {7'd0, PREADY},  8'h00);
    chk("rst_pslverr", {7'd0, PSLVERR}, 8'h00);
    chk("rst_prdata",  PRDATA,          8'h00);
    PRESETn = 1'b1;
    idle(1);

    xfer(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);          // cleared memory
    xfer(1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    idle(1);

    xfer(1'b1, 8'h00, 8'h01, 8'h00, 1'b0);          // back-to-back writes
    xfer(1'b1, 8'h3F, 8'h02, 8'h00, 1'b0);
    xfer(1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
    xfer(1'b0, 8'h3F, 8'h00, 8'h02, 1'b0);
    idle(1);

    xfer(1'b1, 8'h40, 8'h77, 8'h00, OOR_ERR);       // first address past the bank
    xfer(1'b0, 8'h40, 8'h00, 8'h00, OOR_ERR);
    xfer(1'b0, 8'hFF, 8'h00, 8'h00, OOR_ERR);
    xfer(1'b0, 8'h00, 8'h00, 8'h01, 1'b0);          // no aliasing onto addr 0
    idle(1);

    // Abort: PSEL dropped during a wait state.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h20; PWDATA = 8'h3C;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    chk("abort_pready", {7'd0, PREADY}, 8'h00);
    xfer(1'b0, 8'h20, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Protocol violation: access phase without setup.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      chk($sformatf("violation_pready%0d", i), {7'd0, PREADY}, 8'h00);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);

    // Reset mid-transfer, asserted just after PREADY rises.
    xfer(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);          // PRDATA now 0xA5
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 8'h55;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK);
    @(posedge PCLK); #1;
    chk("pre_rst_pready", {7'd0, PREADY}, 8'h01);
    PRESETn = 1'b0;
    #1;
    chk("midrst_pready",  {7'd0, PREADY},  8'h00);
    chk("midrst_pslverr", {7'd0, PSLVERR}, 8'h00);
    chk("midrst_prdata",  PRDATA,          8'h00);
    PSEL = 1'b0; PENABLE = 1'b0;
    idle(2);
    PRESETn = 1'b1;
    xfer(1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
    xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    idle(3);

    chk("queue_empty", 8'(q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

- APB3 completer (slave): an 8-bit register/memory bank with a programmable number of wait states.
- Sits on the completer side of the APB bus. The bridge decodes bit 8 of the 9-bit bus address into PSEL and forwards bits [7:0] as PADDR.
- Answers the bridge's setup/access handshake with PREADY, PRDATA and PSLVERR.
- Serves as the DUT-side responder for the existing APB read/write test environment.

## Interface
Parameters:
- ADDR_WIDTH, 8, PADDR width.
- DATA_WIDTH, 8, PWDATA/PRDATA width.
- MEM_DEPTH, 64, implemented locations 0..MEM_DEPTH-1; must be ≤ 2^ADDR_WIDTH.
- WAIT_STATES, 2, access-phase cycles with PREADY=0 before completion; range 0..15.

Ports (one clock; reset is asynchronous and active-low):
- PCLK  input  1  clock, all state on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response; valid only while PREADY=1.

## Operation
- FSM states are IDLE and ACCESS.
- IDLE → ACCESS: on an edge with PSEL=1, PENABLE=0 (setup phase).
  - Capture PADDR, PWRITE and PWDATA into addr_q/wr_q/wd_q.
  - Load wait counter with WAIT_STATES.
- ACCESS, cnt>0: decrement each edge while PSEL=1 && PENABLE=1.
- ACCESS, cnt==0: PREADY=1.
  - At the next edge with PSEL&&PENABLE, the transfer completes and the FSM returns to IDLE.
  - A write commits to mem[addr_q] at that edge, unless it is an error.
- Abort: PSEL=0 in ACCESS → IDLE at next edge. No write occurs, and PREADY/PSLVERR clear.
- IDLE with PSEL=1, PENABLE=1 (no setup phase): protocol violation. Ignore it, stay IDLE, PREADY stays 0.
- Back-to-back transfers: the setup after a completion is seen in IDLE. Every transfer costs at least 2+WAIT_STATES cycles.
- Out-of-range: addr_q ≥ MEM_DEPTH. Handling is per Configuration.
- Memory: MEM_DEPTH×DATA_WIDTH flops, cleared to 0 on reset.
- Address comparison is unsigned and full-width, with no wrap-around: addresses are not taken modulo MEM_DEPTH.

## Timing
- Reset values: state=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0, memory all 0.
- Reset asserted mid-transfer drops the transfer immediately, with no write. The first setup after PRESETn rises is accepted normally.
- PREADY, PRDATA and PSLVERR are registered.
  - They are loaded on the edge where the FSM enters, or counts down into, the cnt==0 ACCESS condition.
  - With WAIT_STATES=0, this is the setup edge, so PREADY=1 in the first access cycle.
- PRDATA:
  - Read: loaded with mem[addr_q], or 0 on error.
  - Write: holds its previous value.
  - Held unchanged after completion until the next read completes.
- PREADY and PSLVERR clear on the completion edge or the abort edge.
- Latency from setup edge to PREADY=1 is WAIT_STATES+1 cycles. A read returns data in the PREADY cycle.
- Write visibility: a write completing at edge N is readable by a read whose setup is at edge N+1 or later.

## Configuration
- Macro: APB_SLV_ERR_EN.
- Defined:
  - An out-of-range transfer completes with PSLVERR=1 in the PREADY cycle.
  - A write is discarded; a read returns PRDATA=0.
- Undefined:
  - PSLVERR is tied to 0.
  - Out-of-range writes are silently discarded; out-of-range reads return 0.
  - Wait-state timing is unchanged.

## Test plan
- Reset then idle: PRESETn low for 3 cycles → PREADY=0, PSLVERR=0, PRDATA=0x00. A read of 0x05 returns 0x00.
- Write/read, WAIT_STATES=2:
  - Write 0xA5 to 0x10 → PREADY first high 3 cycles after the setup edge.
  - Read 0x10 → PRDATA=0xA5 with PREADY=1, PSLVERR=0.
- Back-to-back writes: 0x01 → addr 0, 0x02 → addr 63 with no idle cycle between. Readback gives 0x01 and 0x02.
- Out-of-range: write 0x77 to 0x40, then read 0x40.
  - With APB_SLV_ERR_EN: PSLVERR=1 on both, PRDATA=0x00.
  - Without it: PSLVERR=0, PRDATA=0x00.
  - In both cases addr 0x00 is unchanged.
- Abort and violation:
  - PSEL dropped during a wait state of a write of 0x3C to 0x20 → readback of 0x20 = prior value.
  - PSEL=1, PENABLE=1 with no setup → PREADY stays 0.
- Reset mid-transfer: PRESETn pulsed low during the ACCESS phase of a write of 0x55 to 0x08 → all outputs 0 immediately, and readback of 0x08 is 0x00.
